keypad_scan_ctrl: RTL and testbench

Sequencing controller for the 4x4 keypad front end of the Booth multiplier input path. It drives the rotating one-hot column strobe consumed by `row_scanner` and the keypad, and freezes the strobe on a press. It debounces press and release, then captures the decoded `key_value` / `is_sign_key` exactly once per physical press. Captured keys are buffered in a small FIFO and presented to the operand-entry logic over a valid/ready handshake.

---
 rtl/keypad_pkg.sv | 28 ++
 rtl/key_fifo.sv | 56 +++++
 rtl/keypad_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types for the keypad front end: FSM states, column reset value, key event record.
// Column helpers keep the rotation order and the one-hot test in one place.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    CAPTURE,
    WAIT_RELEASE
  } scan_state_t;

  localparam logic [3:0] COL_RESET = 4'b1000;

  typedef struct packed {
    logic [3:0] value;
    logic [2:0] sign;
  } key_evt_t;

  // 1000 -> 0100 -> 0010 -> 0001 -> 1000
  function automatic logic [3:0] col_next(input logic [3:0] col);
    return {col[0], col[3:1]};
  endfunction

  function automatic logic is_one_hot(input logic [3:0] r);
    return (r != 4'b0000) && ((r & (r - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous key-event FIFO; head is visible the cycle after the first push.
// Pop frees a slot in the same cycle, so push+pop at full is accepted; otherwise a full push is dropped.
module key_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_vld,
  input  key_evt_t push_dat,
  input  logic     pop_rdy,
  output key_evt_t head_dat,
  output logic     empty,
  output logic     push_dropped
);

  localparam int AW = $clog2(DEPTH);

  key_evt_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            full;
  logic            pop;
  logic            push;

  assign empty        = (count == '0);
  assign full         = (count == (AW+1)'(DEPTH));
  assign pop          = !empty && pop_rdy;
  assign push         = push_vld && (!full || pop);
  assign push_dropped = push_vld && full && !pop;
  assign head_dat     = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad column scanner with press/release debounce, one capture per press; key_valid follows press by DEBOUNCE_CYCLES+2 edges.
// Captured keys queue in key_fifo and drain on key_valid && key_ready; a capture into a full FIFO sets sticky overflow.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCAN_DWELL      = 1,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       slow_clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  input  logic [3:0] key_value,
  input  logic       key_pressed,
  input  logic [2:0] is_sign_key,
  output logic [3:0] col_shift_reg,
  output logic [3:0] key_data,
  output logic [2:0] key_sign,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overflow
);

  localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] DWELL_LAST = 8'(SCAN_DWELL - 1);

  scan_state_t state, state_nxt;
  logic [3:0]  col_nxt;
  logic [7:0]  dwell_cnt, dwell_nxt;
  logic [7:0]  deb_cnt, deb_nxt;
  logic [3:0]  row_lat, row_lat_nxt;
  logic        cap_push;
  logic        rescan;
  logic        fifo_empty;
  logic        fifo_dropped;
  key_evt_t    cap_evt;
  key_evt_t    head_evt;

  always_ff @(posedge slow_clk) begin
    if (rst) begin
      state         <= SCAN;
      col_shift_reg <= COL_RESET;
      dwell_cnt     <= '0;
      deb_cnt       <= '0;
      row_lat       <= '0;
    end else begin
      state         <= state_nxt;
      col_shift_reg <= col_nxt;
      dwell_cnt     <= dwell_nxt;
      deb_cnt       <= deb_nxt;
      row_lat       <= row_lat_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    col_nxt     = col_shift_reg;
    dwell_nxt   = dwell_cnt;
    deb_nxt     = deb_cnt;
    row_lat_nxt = row_lat;
    cap_push    = 1'b0;
    rescan      = 1'b0;
    case (state)
      SCAN: begin
        // Multi-hot rows are ambiguous presses and are simply scanned past.
        if (key_pressed && is_one_hot(row_in)) begin
          row_lat_nxt = row_in;
          deb_nxt     = '0;
          state_nxt   = DEBOUNCE;
        end else if (dwell_cnt == DWELL_LAST) begin
          col_nxt   = col_next(col_shift_reg);
          dwell_nxt = '0;
        end else begin
          dwell_nxt = dwell_cnt + 8'd1;
        end
      end
      DEBOUNCE: begin
        if (row_in == row_lat) begin
          if (deb_cnt == DEB_LAST) begin
            state_nxt = CAPTURE;
            deb_nxt   = '0;
          end else begin
            deb_nxt = deb_cnt + 8'd1;
          end
        end else begin
          rescan = 1'b1;
        end
      end
      CAPTURE: begin
        if (row_in == row_lat) begin
          cap_push  = 1'b1;
          state_nxt = WAIT_RELEASE;
          deb_nxt   = '0;
        end else begin
          rescan = 1'b1;
        end
      end
      WAIT_RELEASE: begin
        if (row_in == 4'b0000) begin
          if (deb_cnt == DEB_LAST) begin
            rescan = 1'b1;
          end else begin
            deb_nxt = deb_cnt + 8'd1;
          end
        end else begin
          deb_nxt = '0;
        end
      end
      default: rescan = 1'b1;
    endcase
    // Every return to SCAN moves on one column and restarts the dwell.
    if (rescan) begin
      state_nxt = SCAN;
      col_nxt   = col_next(col_shift_reg);
      dwell_nxt = '0;
      deb_nxt   = '0;
    end
  end

  assign cap_evt = '{value: key_value, sign: is_sign_key};

  key_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk          (slow_clk),
    .rst          (rst),
    .push_vld     (cap_push),
    .push_dat     (cap_evt),
    .pop_rdy      (key_ready),
    .head_dat     (head_evt),
    .empty        (fifo_empty),
    .push_dropped (fifo_dropped)
  );

  assign key_valid = !fifo_empty;
  assign key_data  = head_evt.value;
  assign key_sign  = head_evt.sign;

  always_ff @(posedge slow_clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (fifo_dropped) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: emulated keypad, behavioural reference model, per-cycle comparison.
module tb_keypad_scan_ctrl;

  localparam int DEB   = 4;
  localparam int DWELL = 1;
  localparam int DEPTH = 4;

  logic       slow_clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in = '0;
  logic [3:0] key_value = '0;
  logic       key_pressed = 1'b0;
  logic [2:0] is_sign_key = '0;
  logic       key_ready = 1'b0;
  logic [3:0] col_shift_reg;
  logic [3:0] key_data;
  logic [2:0] key_sign;
  logic       key_valid;
  logic       overflow;

  keypad_scan_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .SCAN_DWELL     (DWELL),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .slow_clk      (slow_clk),
    .rst           (rst),
    .row_in        (row_in),
    .key_value     (key_value),
    .key_pressed   (key_pressed),
    .is_sign_key   (is_sign_key),
    .col_shift_reg (col_shift_reg),
    .key_data      (key_data),
    .key_sign      (key_sign),
    .key_valid     (key_valid),
    .key_ready     (key_ready),
    .overflow      (overflow)
  );

  always #5 slow_clk = ~slow_clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 scanning, 1 confirming press, 2 taking key, 3 awaiting release.
  int         ph = 0;
  int         m_cnt = 0;
  int         m_age = 0;
  logic [3:0] m_col = 4'b1000;
  logic [3:0] m_lat = '0;
  logic [6:0] m_q[$];
  bit         m_ovf = 1'b0;

  function automatic logic [3:0] rot(input logic [3:0] c);
    return {c[0], c[3:1]};
  endfunction

  function automatic bit onehot(input logic [3:0] r);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(r[i]);
    return n == 1;
  endfunction

  task automatic resume_scan();
    ph = 0; m_col = rot(m_col); m_age = 0; m_cnt = 0;
  endtask

  always @(posedge slow_clk) begin : model
    bit pop, push;
    if (rst) begin
      ph = 0; m_cnt = 0; m_age = 0; m_col = 4'b1000; m_lat = '0; m_ovf = 1'b0;
      m_q.delete();
    end else begin
      pop  = (m_q.size() > 0) && key_ready;
      push = 1'b0;
      case (ph)
        0: if (key_pressed && onehot(row_in)) begin
             m_lat = row_in; m_cnt = 0; ph = 1;
           end else begin
             m_age++;
             if (m_age == DWELL) begin m_col = rot(m_col); m_age = 0; end
           end
        1: if (row_in == m_lat) begin
             m_cnt++;
             if (m_cnt == DEB) begin ph = 2; m_cnt = 0; end
           end else resume_scan();
        2: if (row_in == m_lat) begin push = 1'b1; ph = 3; m_cnt = 0; end
           else resume_scan();
        default: if (row_in == 4'b0000) begin
             m_cnt++;
             if (m_cnt == DEB) resume_scan();
           end else m_cnt = 0;
      endcase
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back({key_value, is_sign_key});
        else m_ovf = 1'b1;
      end
    end
  end

  always @(negedge slow_clk) begin
    if (chk_en) begin
      chk("col_shift_reg", 32'(col_shift_reg), 32'(m_col));
      chk("key_valid", 32'(key_valid), 32'(m_q.size() > 0));
      chk("key_data", 32'(key_data), (m_q.size() > 0) ? 32'(m_q[0][6:3]) : 32'd0);
      chk("key_sign", 32'(key_sign), (m_q.size() > 0) ? 32'(m_q[0][2:0]) : 32'd0);
      chk("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  // Emulated keypad: a held key only shows its row while its column is strobed.
  bit         key_on = 1'b0;
  bit         force_en = 1'b0;
  logic [3:0] force_row = '0;
  logic [3:0] k_col = 4'b1000;
  logic [3:0] k_row = 4'b0001;
  logic [3:0] k_val = '0;
  logic [2:0] k_sign = '0;

  task automatic step();
    row_in      = force_en ? force_row : ((key_on && m_col == k_col) ? k_row : 4'b0000);
    key_pressed = |row_in;
    key_value   = k_val;
    is_sign_key = k_sign;
    @(posedge slow_clk);
    #1;
  endtask

  task automatic set_key(input logic [3:0] c, input logic [3:0] r, input logic [3:0] v, input logic [2:0] s);
    k_col = c; k_row = r; k_val = v; k_sign = s;
  endtask

  task automatic press_release();
    key_on = 1'b1;
    repeat (12) step();
    key_on = 1'b0;
    repeat (6) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    logic [3:0] exp_cols[4];
    exp_cols[0] = 4'b0100; exp_cols[1] = 4'b0010; exp_cols[2] = 4'b0001; exp_cols[3] = 4'b1000;

    // Reset and idle rotation
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    chk("reset_col", 32'(col_shift_reg), 32'h8);
    chk("reset_valid", 32'(key_valid), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_rotation", 32'(col_shift_reg), 32'(exp_cols[i]));
    end

    // Key "5": row 0100 on column 0010
    set_key(4'b0010, 4'b0100, 4'd5, 3'd0);
    key_on = 1'b1;
    n = 0;
    do begin step(); n++; end while (!key_valid && n < 30);
    chk("press5_latency", 32'(n), 32'd8);
    chk("press5_data", 32'(key_data), 32'd5);
    chk("press5_sign", 32'(key_sign), 32'd0);
    repeat (50) step();
    key_on = 1'b0;
    repeat (6) step();
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    chk("held_key_single_entry", 32'(key_valid), 32'd0);

    // Press bounce: two cycles then gone
    n = 0;
    while (m_col != 4'b1000 && n < 8) begin step(); n++; end
    force_en = 1'b1; force_row = 4'b1000;
    step(); step();
    force_row = 4'b0000;
    step();
    chk("bounce_next_col", 32'(col_shift_reg), 32'h4);
    chk("bounce_no_push", 32'(key_valid), 32'd0);
    step();
    chk("bounce_rescan", 32'(col_shift_reg), 32'h2);
    force_en = 1'b0;

    // Release bounce on key "D"
    set_key(4'b1000, 4'b0001, 4'hF, 3'b100);
    key_on = 1'b1;
    n = 0;
    do begin step(); n++; end while (!key_valid && n < 30);
    chk("keyD_data", 32'(key_data), 32'hF);
    chk("keyD_sign", 32'(key_sign), 32'h4);
    key_on = 1'b0;
    step(); step();
    force_en = 1'b1; force_row = 4'b0001;
    step();
    force_en = 1'b0;
    repeat (3) step();
    chk("release_hold_col", 32'(col_shift_reg), 32'h8);
    step();
    chk("release_rescan_col", 32'(col_shift_reg), 32'h4);
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    chk("keyD_single_entry", 32'(key_valid), 32'd0);

    // Five presses with no consumer
    for (int i = 1; i <= 5; i++) begin
      set_key(4'b1000 >> (i % 4), 4'b0010, 4'(i), 3'(i));
      press_release();
    end
    chk("overflow_set", 32'(overflow), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", 32'(key_data), 32'(i));
      key_ready = 1'b1;
      step();
    end
    key_ready = 1'b0;
    chk("drain_empty", 32'(key_valid), 32'd0);
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // Reset mid-debounce with two entries queued
    set_key(4'b0100, 4'b1000, 4'd7, 3'd1);
    press_release();
    set_key(4'b0001, 4'b0100, 4'd8, 3'd2);
    press_release();
    set_key(4'b0010, 4'b0001, 4'd9, 3'd3);
    key_on = 1'b1;
    n = 0;
    while (ph != 1 && n < 10) begin step(); n++; end
    chk("reached_debounce", 32'(ph), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    key_on = 1'b0;
    chk("rst_col", 32'(col_shift_reg), 32'h8);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // Randomised traffic: holds, gaps, glitches (incl. multi-hot), random consumer, rare reset
    for (int e = 0; e < 150; e++) begin
      int hold, gap;
      set_key(4'b0001 << $urandom_range(0, 3), 4'b0001 << $urandom_range(0, 3),
              4'($urandom), 3'($urandom));
      hold = $urandom_range(1, 20);
      gap  = $urandom_range(0, 10);
      for (int c = 0; c < hold + gap; c++) begin
        key_on    = (c < hold);
        key_ready = ($urandom_range(0, 3) == 0);
        force_en  = ($urandom_range(0, 15) == 0);
        force_row = 4'($urandom);
        rst       = ($urandom_range(0, 499) == 0);
        step();
      end
    end
    rst = 1'b0; force_en = 1'b0; key_on = 1'b0; key_ready = 1'b1;
    repeat (10) step();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
